cdc_hs_tx: RTL

CDC_HS_TX -- requirements
Module: cdc_hs_tx

---
 rtl/cdc_hs_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cdc_hs_tx.sv
// rtl/cdc_hs_tx.sv - 4-phase req/ack transmitter moving one word at a time into another clock domain
// Optional one-word holding buffer: define CDC_HS_TX_BUF_EN.
module cdc_hs_tx #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack,
  output logic              tx_done,
  output logic              ack_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tx_done_q, tx_done_d;
  logic              ack_err_q, ack_err_d;
  logic              a_r_q, a_rr_q, a_rrr_q;
  logic              ack_sync;
  logic              accept;

`ifdef CDC_HS_TX_BUF_EN
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  // A second word may be taken whenever the holding buffer has room; in IDLE it is always empty.
  assign in_ready = (state_q == IDLE) || !buf_full_q;
`else
  // Only an idle transmitter can take a word; pure decode of the state register.
  assign in_ready = (state_q == IDLE);
`endif

  assign accept   = in_valid & in_ready;
  assign ack_sync = a_rrr_q;

  assign req      = req_q;
  assign data_out = data_q;
  assign tx_done  = tx_done_q;
  assign ack_err  = ack_err_q;

  // Three-stage synchronizer for the foreign-domain acknowledge; nothing sits between the stages.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_r_q   <= 1'b0;
      a_rr_q  <= 1'b0;
      a_rrr_q <= 1'b0;
    end else begin
      a_r_q   <= ack;
      a_rr_q  <= a_r_q;
      a_rrr_q <= a_rr_q;
    end
  end

  // Next-state, payload capture and status decode for the 4-phase handshake.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    tx_done_d = 1'b0;
    ack_err_d = ack_err_q | ((state_q == IDLE) & ack_sync);
`ifdef CDC_HS_TX_BUF_EN
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
`endif
    case (state_q)
      IDLE: begin
        // An acknowledge seen here is only flagged; a request waits for a real word.
        if (accept) begin
          data_d  = in_data;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_sync) begin
          state_d = REQ_LO;
        end
`ifdef CDC_HS_TX_BUF_EN
        if (accept) begin
          buf_full_d = 1'b1;
          buf_data_d = in_data;
        end
`endif
      end
      REQ_LO: begin
        if (!ack_sync) begin
          tx_done_d = 1'b1;
          state_d   = IDLE;
`ifdef CDC_HS_TX_BUF_EN
          // Chain straight into the next request so no idle cycle is spent between words.
          if (buf_full_q) begin
            data_d     = buf_data_q;
            buf_full_d = 1'b0;
            state_d    = REQ_HI;
          end else if (accept) begin
            data_d  = in_data;
            state_d = REQ_HI;
          end
`endif
        end
`ifdef CDC_HS_TX_BUF_EN
        else if (accept) begin
          buf_full_d = 1'b1;
          buf_data_d = in_data;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // req is registered alongside the state so it toggles on the same edge and never glitches.
    req_d = (state_d == REQ_HI);
  end

  // State, request, payload and status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      data_q    <= '0;
      tx_done_q <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      data_q    <= data_d;
      tx_done_q <= tx_done_d;
      ack_err_q <= ack_err_d;
    end
  end

`ifdef CDC_HS_TX_BUF_EN
  // Holding buffer for a word offered while a handshake is in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
    end
  end
`endif

endmodule
